// File: rtl/ntp_clock_select.sv
// Chooses between NTP clock instances A and B: health-driven failover, hold-off
// revert to the preferred source, forced mode and a saturating failover counter.
module ntp_clock_select #(
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              cfg_enable,
  input  logic              cfg_prefer_b,
  input  logic              cfg_force,
  input  logic [CNT_W-1:0]  cfg_holdoff,
  input  logic              cfg_clr_cnt,
  input  logic              sync_ok_a,
  input  logic              pll_locked_a,
  input  logic [63:0]       time_a,
  input  logic              time_upd_a,
  input  logic              sync_ok_b,
  input  logic              pll_locked_b,
  input  logic [63:0]       time_b,
  input  logic              time_upd_b,
  output logic [63:0]       ntp_time,
  output logic              ntp_time_upd,
  output logic              time_valid,
  output logic              sel_b,
  output logic              sel_changed,
  output logic [FCNT_W-1:0] failover_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    USE_A = 2'd1,
    USE_B = 2'd2
  } state_t;

  state_t             st, st_nxt;
  state_t             pref_st, other_st, alt_st;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic               fo_inc;
  logic               sel_nxt;
  logic [FCNT_W-1:0]  fcnt_nxt;
  logic               healthy_a, healthy_b, healthy_pref, healthy_other;
  logic               healthy_cur, healthy_alt;

  assign healthy_a     = sync_ok_a & pll_locked_a;
  assign healthy_b     = sync_ok_b & pll_locked_b;
  assign pref_st       = cfg_prefer_b ? USE_B : USE_A;
  assign other_st      = cfg_prefer_b ? USE_A : USE_B;
  assign healthy_pref  = cfg_prefer_b ? healthy_b : healthy_a;
  assign healthy_other = cfg_prefer_b ? healthy_a : healthy_b;
  // Health of the source in use and of the alternative one.
  assign healthy_cur   = (st == USE_B) ? healthy_b : healthy_a;
  assign healthy_alt   = (st == USE_B) ? healthy_a : healthy_b;
  assign alt_st        = (st == USE_B) ? USE_A : USE_B;

  // Next-state, hold-off and failover decision.
  always_comb begin
    st_nxt   = st;
    hold_nxt = '0;
    fo_inc   = 1'b0;
    if (!cfg_enable) begin
      st_nxt = NONE;
    end else if (cfg_force) begin
      st_nxt = pref_st;
    end else begin
      case (st)
        NONE: begin
          if (healthy_pref)       st_nxt = pref_st;
          else if (healthy_other) st_nxt = other_st;
        end
        default: begin
          if (!healthy_cur) begin
            if (healthy_alt) begin
              st_nxt = alt_st;
              fo_inc = 1'b1;
            end else begin
              st_nxt = NONE;
            end
          end else if (st != pref_st && healthy_pref) begin
            if (hold_cnt >= cfg_holdoff) st_nxt = pref_st;
            else hold_nxt = (&hold_cnt) ? hold_cnt : hold_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    sel_nxt = sel_b;
    if (st_nxt == USE_B)      sel_nxt = 1'b1;
    else if (st_nxt == USE_A) sel_nxt = 1'b0;
  end

  // A clear coinciding with a failover leaves exactly that one failover counted.
  always_comb begin
    fcnt_nxt = failover_cnt;
    if (cfg_clr_cnt)                    fcnt_nxt = fo_inc ? FCNT_W'(1) : '0;
    else if (fo_inc && !(&failover_cnt)) fcnt_nxt = failover_cnt + FCNT_W'(1);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      st           <= NONE;
      hold_cnt     <= '0;
      sel_b        <= 1'b0;
      sel_changed  <= 1'b0;
      failover_cnt <= '0;
    end else begin
      st           <= st_nxt;
      hold_cnt     <= hold_nxt;
      sel_b        <= sel_nxt;
      sel_changed  <= sel_nxt ^ sel_b;
      failover_cnt <= fcnt_nxt;
    end
  end

  // Time path follows the current selection with one cycle of latency.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ntp_time     <= '0;
      ntp_time_upd <= 1'b0;
      time_valid   <= 1'b0;
    end else begin
      case (st)
        USE_A: begin
          ntp_time     <= time_a;
          ntp_time_upd <= time_upd_a;
          time_valid   <= healthy_a;
        end
        USE_B: begin
          ntp_time     <= time_b;
          ntp_time_upd <= time_upd_b;
          time_valid   <= healthy_b;
        end
        default: begin
          ntp_time_upd <= 1'b0;
          time_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_ntp_clock_select.sv
// Directed bench for ntp_clock_select: rule-level model checked every cycle,
// plus literal expectations for the test-plan scenarios.
module tb_ntp_clock_select;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0, cfg_prefer_b = 1'b0, cfg_force = 1'b0, cfg_clr_cnt = 1'b0;
  logic [23:0] cfg_holdoff = 24'd0;
  logic        sync_ok_a = 1'b0, pll_locked_a = 1'b0, time_upd_a = 1'b0;
  logic        sync_ok_b = 1'b0, pll_locked_b = 1'b0, time_upd_b = 1'b0;
  logic [63:0] time_a = 64'd0, time_b = 64'd0;
  logic [63:0] ntp_time;
  logic        ntp_time_upd, time_valid, sel_b, sel_changed;
  logic [15:0] failover_cnt;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  ntp_clock_select #(.CNT_W(24), .FCNT_W(16)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .cfg_enable(cfg_enable), .cfg_prefer_b(cfg_prefer_b), .cfg_force(cfg_force),
    .cfg_holdoff(cfg_holdoff), .cfg_clr_cnt(cfg_clr_cnt),
    .sync_ok_a(sync_ok_a), .pll_locked_a(pll_locked_a), .time_a(time_a), .time_upd_a(time_upd_a),
    .sync_ok_b(sync_ok_b), .pll_locked_b(pll_locked_b), .time_b(time_b), .time_upd_b(time_upd_b),
    .ntp_time(ntp_time), .ntp_time_upd(ntp_time_upd), .time_valid(time_valid),
    .sel_b(sel_b), .sel_changed(sel_changed), .failover_cnt(failover_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: selection as integer 0=none, 1=A, 2=B; hold-off as a streak length.
  int          m_st, m_run, m_fcnt;
  logic [63:0] m_time;
  bit          m_upd, m_valid, m_sel, m_chg;

  always @(posedge clk or negedge rst_n) begin
    int  nst, pref, alt, run;
    bit  ha, hb, hp, ho, hcur, halt, inc, nsel;
    if (!rst_n) begin
      m_st = 0; m_run = 0; m_fcnt = 0; m_time = 64'd0;
      m_upd = 0; m_valid = 0; m_sel = 0; m_chg = 0;
    end else begin
      ha = sync_ok_a && pll_locked_a;
      hb = sync_ok_b && pll_locked_b;
      pref = cfg_prefer_b ? 2 : 1;
      hp = cfg_prefer_b ? hb : ha;
      ho = cfg_prefer_b ? ha : hb;
      if (m_st == 1)      begin m_time = time_a; m_upd = time_upd_a; m_valid = ha; end
      else if (m_st == 2) begin m_time = time_b; m_upd = time_upd_b; m_valid = hb; end
      else                begin m_upd = 0; m_valid = 0; end
      nst = m_st; inc = 0; run = 0;
      if (!cfg_enable) nst = 0;
      else if (cfg_force) nst = pref;
      else if (m_st == 0) nst = hp ? pref : (ho ? 3 - pref : 0);
      else begin
        alt  = 3 - m_st;
        hcur = (m_st == 1) ? ha : hb;
        halt = (m_st == 1) ? hb : ha;
        if (!hcur) begin
          nst = halt ? alt : 0;
          inc = halt;
        end else if (m_st != pref && hp) begin
          if (m_run >= int'(cfg_holdoff)) nst = pref;
          else run = (m_run + 1 > 24'hFF_FFFF) ? 24'hFF_FFFF : m_run + 1;
        end
      end
      m_run = run;
      nsel = (nst == 2) ? 1'b1 : ((nst == 1) ? 1'b0 : m_sel);
      m_chg = (nsel != m_sel);
      m_sel = nsel;
      if (cfg_clr_cnt) m_fcnt = inc ? 1 : 0;
      else if (inc && m_fcnt < 65535) m_fcnt = m_fcnt + 1;
      m_st = nst;
    end
  end

  always @(negedge clk) begin
    chk("m_state", {62'd0, state}, 64'(m_st));
    chk("m_ntp_time", ntp_time, m_time);
    chk("m_upd", {63'd0, ntp_time_upd}, {63'd0, m_upd});
    chk("m_valid", {63'd0, time_valid}, {63'd0, m_valid});
    chk("m_sel_b", {63'd0, sel_b}, {63'd0, m_sel});
    chk("m_sel_changed", {63'd0, sel_changed}, {63'd0, m_chg});
    chk("m_failover_cnt", {48'd0, failover_cnt}, 64'(m_fcnt));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_health(input bit a, input bit b);
    sync_ok_a = a; pll_locked_a = 1'b1;
    sync_ok_b = b; pll_locked_b = 1'b1;
  endtask

  logic [63:0] frozen;
  int          k;

  initial begin
    // Reset state and first selection.
    cfg_enable = 1'b1; cfg_prefer_b = 1'b0; cfg_holdoff = 24'd100;
    set_health(1, 1);
    time_a = 64'h0000_0001_8000_0000; time_b = 64'h0000_0002_4000_0000;
    time_upd_a = 1'b1; time_upd_b = 1'b1;
    step(2);
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_ntp_time", ntp_time, 64'd0);
    chk("rst_fcnt", {48'd0, failover_cnt}, 64'd0);
    rst_n = 1'b1;
    step(1);
    chk("t1_state", {62'd0, state}, 64'd1);
    step(1);
    chk("t1_ntp_time", ntp_time, 64'h0000_0001_8000_0000);
    chk("t1_valid", {63'd0, time_valid}, 64'd1);
    chk("t1_sel_b", {63'd0, sel_b}, 64'd0);

    // Failover A -> B.
    sync_ok_a = 1'b0;
    step(1);
    chk("t2_state", {62'd0, state}, 64'd2);
    chk("t2_sel_changed", {63'd0, sel_changed}, 64'd1);
    chk("t2_fcnt", {48'd0, failover_cnt}, 64'd1);
    step(1);
    chk("t2_ntp_time", ntp_time, 64'h0000_0002_4000_0000);

    // Hold-off revert with a glitch on A.
    sync_ok_a = 1'b1;
    step(50);
    chk("t3_no_early_revert", {62'd0, state}, 64'd2);
    sync_ok_a = 1'b0;
    step(1);
    sync_ok_a = 1'b1;
    k = 0;
    while (state != 2'd1 && k < 300) begin
      step(1);
      k++;
    end
    chk("t3_revert_edges", 64'(k), 64'd101);
    chk("t3_fcnt", {48'd0, failover_cnt}, 64'd1);

    // Both lost together -> NONE with frozen time; both restored -> preferred.
    set_health(0, 0);
    step(1);
    chk("t4_state", {62'd0, state}, 64'd0);
    step(1);
    frozen = ntp_time;
    chk("t4_valid", {63'd0, time_valid}, 64'd0);
    chk("t4_upd", {63'd0, ntp_time_upd}, 64'd0);
    time_a = 64'h0000_0003_0000_0001;
    step(2);
    chk("t4_frozen", ntp_time, frozen);
    chk("t4_fcnt", {48'd0, failover_cnt}, 64'd1);
    set_health(1, 1);
    step(1);
    chk("t4_restore", {62'd0, state}, 64'd1);

    // Forced selection of an unhealthy preferred source.
    cfg_force = 1'b1; cfg_prefer_b = 1'b1; set_health(1, 0);
    step(1);
    chk("t5_state", {62'd0, state}, 64'd2);
    step(1);
    chk("t5_valid", {63'd0, time_valid}, 64'd0);
    chk("t5_fcnt", {48'd0, failover_cnt}, 64'd1);
    cfg_force = 1'b0;
    step(1);
    chk("t5_unforce", {62'd0, state}, 64'd1);
    chk("t5_unforce_fcnt", {48'd0, failover_cnt}, 64'd2);

    // Saturation, clear-with-increment and asynchronous reset.
    cfg_clr_cnt = 1'b1;
    step(1);
    cfg_clr_cnt = 1'b0;
    chk("t6_clr", {48'd0, failover_cnt}, 64'd0);
    for (int i = 0; i < 65535; i++) begin
      set_health(i[0], !i[0]);
      step(1);
    end
    chk("t6_full", {48'd0, failover_cnt}, 64'hFFFF);
    set_health(1, 0);
    step(1);
    chk("t6_sat", {48'd0, failover_cnt}, 64'hFFFF);
    set_health(0, 1); cfg_clr_cnt = 1'b1;
    step(1);
    cfg_clr_cnt = 1'b0;
    chk("t6_clr_inc", {48'd0, failover_cnt}, 64'd1);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_time", ntp_time, 64'd0);
    chk("t6_rst_state", {62'd0, state}, 64'd0);
    chk("t6_rst_sel_b", {63'd0, sel_b}, 64'd0);
    chk("t6_rst_fcnt", {48'd0, failover_cnt}, 64'd0);
    chk("t6_rst_valid", {63'd0, time_valid}, 64'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("t6_after_rst", {62'd0, state}, 64'd2);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
